// File: rtl/tracker_pkg.sv
// Shared types and constants for the cursor-trace grid tracker.
package tracker_pkg;

   // Default geometry of the VGA bench grid
   localparam int unsigned DEF_HCELLS   = 96;
   localparam int unsigned DEF_VCELLS   = 54;
   localparam int unsigned DEF_CELL_PIX = 5;
   localparam int unsigned DEF_CNT_W    = 17;
   localparam int unsigned DEF_PIX_W    = 12;

   // Cell area in screen pixels, added to pixel_cnt per newly painted cell
   localparam int unsigned DEF_CELL_AREA = DEF_CELL_PIX * DEF_CELL_PIX;

   // Index widths for the default grid
   localparam int unsigned DEF_ROW_W = $clog2(DEF_VCELLS);
   localparam int unsigned DEF_COL_W = $clog2(DEF_HCELLS);

   // Button bit positions; lower index wins when edges coincide
   localparam int unsigned BTN_N     = 4;
   localparam int unsigned BTN_RIGHT = 0;
   localparam int unsigned BTN_UP    = 1;
   localparam int unsigned BTN_DOWN  = 2;
   localparam int unsigned BTN_LEFT  = 3;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_UP    = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      CLEAR = 2'd2
   } state_e;

   function automatic int unsigned cell_area(input int unsigned cell_pix);
      return cell_pix * cell_pix;
   endfunction

endpackage

// File: rtl/grid_tracker_btn_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse, one lane per bit.
module btn_edge_sync #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] btn_i,
   output logic [W-1:0] pulse_o
);

   logic [W-1:0] sync1_q, sync1_d;
   logic [W-1:0] sync2_q, sync2_d;
   logic [W-1:0] prev_q,  prev_d;
   logic [W-1:0] pulse_q, pulse_d;

   // Next-state: shift raw buttons through the synchroniser, flag rising edges
   always_comb begin
      sync1_d = btn_i;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pulse_d = sync2_q & ~prev_q;
   end

   // Synchroniser and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pulse_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/grid_tracker.sv
// Cursor-trace tracker: button edges move a cursor over a cell grid, visited
// cells are latched in a bitmap with an incremental painted-pixel count, and
// raster coordinates are looked up for display.
// Build option: define TRACKER_WRAP_EN for toroidal wrap instead of edge clamp.
module grid_tracker
   import tracker_pkg::*;
#(
   parameter int unsigned HCELLS   = DEF_HCELLS,
   parameter int unsigned VCELLS   = DEF_VCELLS,
   parameter int unsigned CELL_PIX = DEF_CELL_PIX,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned PIX_W    = DEF_PIX_W
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [3:0]                 PushButton,
   input  logic                       clear,
   input  logic [PIX_W-1:0]           pix_x,
   input  logic [PIX_W-1:0]           pix_y,
   output logic                       on,
   output logic                       on_cursor,
   output logic [CNT_W-1:0]           pixel_cnt,
   output logic [$clog2(VCELLS)-1:0]  cur_row,
   output logic [$clog2(HCELLS)-1:0]  cur_col,
   output logic                       busy
);

   localparam int unsigned ROW_W     = $clog2(VCELLS);
   localparam int unsigned COL_W     = $clog2(HCELLS);
   localparam int unsigned CELL_AREA = cell_area(CELL_PIX);

   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(VCELLS - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(HCELLS - 1);

   logic [BTN_N-1:0] pulse;

   state_e            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              mark_q, mark_d;
   logic [ROW_W-1:0]  clr_row_q, clr_row_d;
   logic [HCELLS-1:0] bitmap_q [VCELLS];
   logic [HCELLS-1:0] bitmap_d [VCELLS];
   logic              on_q, on_d;
   logic              on_cursor_q, on_cursor_d;

   logic              any_pulse;
   dir_e              dir;
   logic [PIX_W-1:0]  pcol, prow;
   logic              in_grid;
   logic [ROW_W-1:0]  drow;
   logic [COL_W-1:0]  dcol;

   btn_edge_sync #(.W(BTN_N)) u_btn (
      .clk     (CLK),
      .rst_n   (RESET),
      .btn_i   (PushButton),
      .pulse_o (pulse)
   );

   // Priority-resolve simultaneous edges: right > up > down > left
   always_comb begin
      any_pulse = |pulse;
      dir       = DIR_LEFT;
      if (pulse[BTN_RIGHT])     dir = DIR_RIGHT;
      else if (pulse[BTN_UP])   dir = DIR_UP;
      else if (pulse[BTN_DOWN]) dir = DIR_DOWN;
   end

   // Tracker FSM: arming, cursor moves, deferred marking and row-wise clear
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      mark_d    = 1'b0;
      clr_row_d = clr_row_q;
      bitmap_d  = bitmap_q;

      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d   = CLEAR;
               busy_d    = 1'b1;
               clr_row_d = '0;
            end else if (any_pulse) begin
               state_d        = TRACK;
               row_d          = '0;
               col_d          = '0;
               bitmap_d[0][0] = 1'b1;
               cnt_d          = CNT_W'(CELL_AREA);
            end
         end
         TRACK: begin
            if (clear) begin
               state_d   = CLEAR;
               busy_d    = 1'b1;
               clr_row_d = '0;
            end else begin
               // Mark the cell the cursor landed on last cycle
               if (mark_q && !bitmap_q[row_q][col_q]) begin
                  bitmap_d[row_q][col_q] = 1'b1;
                  cnt_d                  = cnt_q + CNT_W'(CELL_AREA);
               end
               if (any_pulse) begin
                  mark_d = 1'b1;
                  case (dir)
                     DIR_RIGHT: begin
                        if (col_q != COL_MAX)  col_d = col_q + COL_W'(1);
`ifdef TRACKER_WRAP_EN
                        else                   col_d = '0;
`endif
                     end
                     DIR_UP: begin
                        if (row_q != ROW_MAX)  row_d = row_q + ROW_W'(1);
`ifdef TRACKER_WRAP_EN
                        else                   row_d = '0;
`endif
                     end
                     DIR_DOWN: begin
                        if (row_q != '0)       row_d = row_q - ROW_W'(1);
`ifdef TRACKER_WRAP_EN
                        else                   row_d = ROW_MAX;
`endif
                     end
                     default: begin
                        if (col_q != '0)       col_d = col_q - COL_W'(1);
`ifdef TRACKER_WRAP_EN
                        else                   col_d = COL_MAX;
`endif
                     end
                  endcase
               end
            end
         end
         CLEAR: begin
            bitmap_d[clr_row_q] = '0;
            if (clr_row_q == ROW_MAX) begin
               state_d   = IDLE;
               busy_d    = 1'b0;
               row_d     = '0;
               col_d     = '0;
               cnt_d     = '0;
               clr_row_d = '0;
            end else begin
               clr_row_d = clr_row_q + ROW_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Display lookup: map raster pixel to a cell, row 0 at the bottom
   always_comb begin
      pcol        = pix_x / PIX_W'(CELL_PIX);
      prow        = pix_y / PIX_W'(CELL_PIX);
      in_grid     = (pcol < PIX_W'(HCELLS)) && (prow < PIX_W'(VCELLS));
      drow        = ROW_W'(PIX_W'(VCELLS - 1) - prow);
      dcol        = COL_W'(pcol);
      on_d        = 1'b0;
      on_cursor_d = 1'b0;
      if (in_grid) begin
         on_d        = bitmap_q[drow][dcol];
         on_cursor_d = (state_q == TRACK) && (drow == row_q) && (dcol == col_q);
      end
   end

   // State, bitmap and output registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         mark_q      <= 1'b0;
         clr_row_q   <= '0;
         on_q        <= 1'b0;
         on_cursor_q <= 1'b0;
         for (int unsigned r = 0; r < VCELLS; r++) begin
            bitmap_q[r] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         mark_q      <= mark_d;
         clr_row_q   <= clr_row_d;
         on_q        <= on_d;
         on_cursor_q <= on_cursor_d;
         bitmap_q    <= bitmap_d;
      end
   end

   assign on        = on_q;
   assign on_cursor = on_cursor_q;
   assign pixel_cnt = cnt_q;
   assign cur_row   = row_q;
   assign cur_col   = col_q;
   assign busy      = busy_q;

endmodule
